// File: rtl/sram_rr_arbiter.sv
// Two-requester round-robin front end for a single-port SRAM with a 1-cycle registered read.
// Grants are combinational; read data is routed back to the requester that issued the read.
module sram_rr_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [CNT_W-1:0]  conflict_cnt
);

  // Owner encoding: 0 = A, 1 = B.
  localparam logic OWN_B = 1'b1;

  logic              last_q, last_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_owner_q, rd_owner_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  logic              gnt, win_b, w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    // Grants are gated by rst_n so nothing reaches the SRAM while reset is held.
    if (rst_n) begin
      if (a_req && (!b_req || last_q == OWN_B)) a_gnt = 1'b1;
      else if (b_req)                            b_gnt = 1'b1;
    end
    gnt     = a_gnt | b_gnt;
    win_b   = b_gnt;
    w_we    = win_b ? b_we    : a_we;
    w_addr  = win_b ? b_addr  : a_addr;
    w_wdata = win_b ? b_wdata : a_wdata;

    mem_we     = gnt & w_we;
    mem_addr_d = gnt ? w_addr  : mem_addr_q;
    mem_din_d  = gnt ? w_wdata : mem_din_q;
    mem_addr   = mem_addr_d;
    mem_din    = mem_din_d;

    last_d     = gnt ? win_b : last_q;
    rd_pend_d  = gnt & ~w_we;
    rd_owner_d = gnt ? win_b : rd_owner_q;

    a_rvalid  = rd_pend_q & (rd_owner_q != OWN_B);
    b_rvalid  = rd_pend_q & (rd_owner_q == OWN_B);
    // Live SRAM data during the valid cycle, captured copy otherwise.
    a_rdata   = a_rvalid ? mem_dout : a_rdata_q;
    b_rdata   = b_rvalid ? mem_dout : b_rdata_q;
    a_rdata_d = a_rdata;
    b_rdata_d = b_rdata;

    cnt_d = cnt_q;
    if (a_req && b_req && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    conflict_cnt = cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= OWN_B;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      cnt_q      <= '0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      last_q     <= last_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      cnt_q      <= cnt_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter with an 8x8 registered-read SRAM model;
// read returns are checked by a scoreboard queue drained by an independent monitor.
module tb_sram_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [2:0] a_addr = 0, b_addr = 0;
  logic [7:0] a_wdata = 0, b_wdata = 0;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid, mem_we;
  logic [7:0] a_rdata, b_rdata, mem_din, conflict_cnt;
  logic [2:0] mem_addr;
  logic [7:0] mem_dout = 8'h00;
  logic [7:0] sram [8];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { logic owner; logic [7:0] data; } rd_exp_t;
  rd_exp_t sb[$];

  always #5 clk = ~clk;

  sram_rr_arbiter #(.ADDR_W(3), .DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .conflict_cnt(conflict_cnt)
  );

  initial for (int i = 0; i < 8; i++) sram[i] = 8'h00;

  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_din;
    mem_dout <= sram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rvalid pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rst_n && (a_rvalid || b_rvalid)) begin
      rd_exp_t e;
      if (a_rvalid && b_rvalid) begin
        chk("rvalid_both", 32'd1, 32'd0);
      end else if (sb.size() == 0) begin
        chk("rvalid_unexpected", {31'd0, b_rvalid}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("rd_owner", {31'd0, b_rvalid}, {31'd0, e.owner});
        chk("rd_data", {24'd0, (b_rvalid ? b_rdata : a_rdata)}, {24'd0, e.data});
      end
    end
  end

  // One cycle: drive at posedge+1, check grant at negedge, queue expected read.
  // eg = expected {b_gnt, a_gnt}; rd = expected read data if the grant is a read.
  task automatic cyc(input logic ar, input logic aw, input logic [2:0] aa, input logic [7:0] ad,
                     input logic br, input logic bw, input logic [2:0] ba, input logic [7:0] bd,
                     input logic [1:0] eg, input logic [7:0] rd);
    rd_exp_t e;
    @(posedge clk); #1;
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    @(negedge clk);
    chk("grant", {30'd0, b_gnt, a_gnt}, {30'd0, eg});
    if (eg != 2'b00) begin
      chk("mem_addr", {29'd0, mem_addr}, {29'd0, eg[1] ? ba : aa});
      chk("mem_we", {31'd0, mem_we}, {31'd0, eg[1] ? bw : aw});
      if (!(eg[1] ? bw : aw)) begin
        e.owner = eg[1];
        e.data  = rd;
        sb.push_back(e);
      end
    end else begin
      chk("mem_we_idle", {31'd0, mem_we}, 32'd0);
    end
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 8'h00);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    a_req = 0; b_req = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state, with both requests asserted while held in reset
    a_req = 1; b_req = 1; a_we = 1; a_addr = 3'd5; a_wdata = 8'hC3;
    #12;
    chk("rst_a_gnt", {31'd0, a_gnt}, 0);
    chk("rst_b_gnt", {31'd0, b_gnt}, 0);
    chk("rst_mem_we", {31'd0, mem_we}, 0);
    chk("rst_mem_addr", {29'd0, mem_addr}, 0);
    chk("rst_cnt", {24'd0, conflict_cnt}, 0);
    chk("rst_rvalid", {30'd0, a_rvalid, b_rvalid}, 0);
    chk("rst_rdata", {16'd0, a_rdata, b_rdata}, 0);
    @(posedge clk); #1;
    a_req = 0; b_req = 0; a_we = 0;
    rst_n = 1'b1;

    // Single A write then read
    cyc(1, 1, 3'd3, 8'h5A, 0, 0, 0, 0, 2'b01, 8'h00);
    chk("t1_mem_din", {24'd0, mem_din}, 32'h5A);
    cyc(1, 0, 3'd3, 8'h00, 0, 0, 0, 0, 2'b01, 8'h5A);
    idle();
    chk("t1_a_rdata_hold", {24'd0, a_rdata}, 32'h5A);
    idle();
    chk("t1_mem_addr_hold", {29'd0, mem_addr}, 3);

    // Contention alternation from reset (last_grant = B)
    do_reset();
    for (int i = 0; i < 6; i++)
      cyc(1, 0, 3'd3, 0, 1, 0, 3'd4, 0, (i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 0) ? 8'h5A : 8'h00);
    idle();
    chk("t2_cnt6", {24'd0, conflict_cnt}, 6);
    idle();

    // Back-to-back mixed
    cyc(1, 1, 3'd0, 8'h11, 0, 0, 0, 0, 2'b01, 8'h00);
    cyc(0, 0, 0, 0, 1, 1, 3'd1, 8'h22, 2'b10, 8'h00);
    cyc(1, 0, 3'd0, 0, 0, 0, 0, 0, 2'b01, 8'h11);
    cyc(0, 0, 0, 0, 1, 0, 3'd1, 0, 2'b10, 8'h22);
    idle();
    chk("t3_a_rdata_kept", {24'd0, a_rdata}, 32'h11);
    chk("t3_b_rvalid", {31'd0, b_rvalid}, 1);
    idle();

    // Read-before-write ordering on addr 2 (still 0x00)
    cyc(1, 0, 3'd2, 0, 0, 0, 0, 0, 2'b01, 8'h00);
    cyc(0, 0, 0, 0, 1, 1, 3'd2, 8'hFF, 2'b10, 8'h00);
    cyc(1, 0, 3'd2, 0, 0, 0, 0, 0, 2'b01, 8'hFF);
    idle();
    idle();

    // Saturation: 300 conflict cycles of writes
    do_reset();
    @(posedge clk); #1;
    a_req = 1; a_we = 1; a_addr = 3'd7; a_wdata = 8'h01;
    b_req = 1; b_we = 1; b_addr = 3'd7; b_wdata = 8'h02;
    repeat (299) @(posedge clk);
    #1;
    chk("t5_cnt_pre", {24'd0, conflict_cnt}, 255);
    @(posedge clk); #1;
    a_req = 0; b_req = 0; a_we = 0; b_we = 0;
    @(negedge clk);
    chk("t5_cnt_sat", {24'd0, conflict_cnt}, 255);

    // Async reset mid-read
    do_reset();
    @(posedge clk); #1;
    a_req = 1; a_we = 0; a_addr = 3'd3;
    #2;
    chk("t6_gnt_before", {31'd0, a_gnt}, 1);
    b_req = 1; b_we = 0; b_addr = 3'd4;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_gnt", {30'd0, b_gnt, a_gnt}, 0);
    chk("t6_rst_we", {31'd0, mem_we}, 0);
    @(posedge clk); @(posedge clk); #1;
    chk("t6_rst_cnt", {24'd0, conflict_cnt}, 0);
    chk("t6_rst_rvalid", {30'd0, a_rvalid, b_rvalid}, 0);
    a_req = 0; b_req = 0;
    rst_n = 1'b1;
    cyc(1, 0, 3'd3, 0, 1, 0, 3'd4, 0, 2'b01, 8'h5A);
    idle();
    idle();

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/sram_rr_arbiter.md
Name: sram_rr_arbiter

Overview:
- Two-port round-robin arbiter sharing the single-port 8x8 SRAM (1-cycle registered read) between requesters A and B.
- Accepts at most one access per cycle and drives the SRAM address, write-enable and write-data.
- Tags each accepted read and returns the SRAM output to the owning requester with a one-cycle read-valid pulse.
- Counts contention cycles for debug.

Parameters:
- ADDR_W, 3, SRAM address width.
- DATA_W, 8, SRAM data width.
- CNT_W, 8, width of the saturating contention counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_req  in  1  requester A access request.
- a_we  in  1  A: 1 = write, 0 = read.
- a_addr  in  ADDR_W  A address.
- a_wdata  in  DATA_W  A write data.
- a_gnt  out  1  A access accepted this cycle.
- a_rvalid  out  1  A read data valid.
- a_rdata  out  DATA_W  A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for requester B.
- mem_we  out  1  to SRAM we.
- mem_addr  out  ADDR_W  to SRAM addr.
- mem_din  out  DATA_W  to SRAM din.
- mem_dout  in  DATA_W  from SRAM dout; valid the cycle after the address is presented.
- conflict_cnt  out  CNT_W  saturating count of cycles with a_req & b_req.

Behaviour:
- Handshake: a transfer occurs in a cycle where x_req & x_gnt. x_gnt is combinational from the req inputs and the state. A requester holds req/we/addr/wdata stable until granted.
- Arbitration:
  - Only one requester active: it is granted.
  - Both active: grant goes to the requester NOT recorded in last_grant.
  - No request: no grant; mem_we=0; mem_addr/mem_din hold the last-granted values (no toggling).
- last_grant register updates on every granted cycle to the winner. Reset value = B, so A wins the first conflict.
- SRAM drive: mem_we = winner_we & grant; mem_addr/mem_din = winner's addr/wdata, same cycle as the grant.
- Read return pipeline:
  - On a granted read, register rd_pend=1 and rd_owner=winner.
  - Next cycle: x_rvalid=1 for rd_owner only, for exactly 1 cycle, with x_rdata = mem_dout. Read latency is grant + 1 cycle.
  - x_rdata is registered: it holds its last value when rvalid=0 and is never overwritten by the other requester's data.
  - Back-to-back reads (A then B, or A then A) on consecutive cycles return in order, one per cycle. No bubbles are required.
- Writes produce no rvalid.
- Read and write to the same address in consecutive cycles: the read returns data per SRAM timing. A read granted in the cycle before the write returns the old value. A read granted after the write returns the new value.
- conflict_cnt: +1 on each cycle with a_req & b_req; saturates at 2^CNT_W-1 with no wrap.
- Reset (rst_n low, asynchronous, any cycle):
  - a_gnt, b_gnt, mem_we forced 0 combinationally while rst_n=0.
  - rvalid outputs = 0; rdata = 0; rd_pend = 0; last_grant = B; conflict_cnt = 0; mem_addr/mem_din = 0.
  - A read granted the cycle before reset asserts is dropped: no rvalid after release.
- Deassertion: arbitration resumes on the first rising edge with rst_n=1. The block is usable in that same cycle.

Test Plan:
- Single A write then read: A writes 0x5A to addr 3 (a_gnt=1 that cycle, mem_we=1, mem_addr=3), then reads addr 3 -> a_rvalid=1 exactly one cycle later, a_rdata=0x5A, b_rvalid stays 0.
- Contention alternation: a_req=b_req=1 continuously, both reads, 6 cycles -> grants A,B,A,B,A,B. rvalid pulses alternate with 1-cycle lag. conflict_cnt=6.
- Back-to-back mixed: pre-load addr0=0x11, addr1=0x22. A reads 0 at cycle t, B reads 1 at t+1 -> a_rvalid at t+1 with 0x11, b_rvalid at t+2 with 0x22, a_rdata still 0x11 at t+2.
- Read-before-write ordering: addr2=0x00. A reads 2 at t, B writes 0xFF to 2 at t+1, A reads 2 at t+2 -> returns 0x00 then 0xFF.
- Saturation: hold both requests for 300 cycles with CNT_W=8 -> conflict_cnt=255, no wrap.
- Async reset mid-read: grant an A read, pull rst_n low before the next edge -> a_rvalid never asserts. All grants, mem_we and conflict_cnt are 0 during reset. After release, the first conflict is granted to A.
